// File: rtl/hc16_mw_add_sched_pkg.sv
// Shared types and the round-robin pick helper for the multi-word add scheduler.
// Optional carry-in support is selected with HC16_SCHED_CIN_EN in the interface and top.
package hc16_sched_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    RESP = 2'd3
  } state_t;

  // First set bit of valid at or after ptr, wrapping within mask+1 requesters.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input logic [2:0] mask);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (ptr + 3'(i)) & mask;
      if (!found && (3'(i) <= mask) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hc16_mw_add_sched_if.sv
// Requester/response bundle for hc16_mw_add_sched; master = clients, slave = scheduler.
// req_cin exists only when HC16_SCHED_CIN_EN is defined.
interface hc16_mw_add_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_WORDS = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*MAX_WORDS*16-1:0] req_a;
  logic [NUM_REQ*MAX_WORDS*16-1:0] req_b;
  logic [NUM_REQ*2-1:0]            req_nwords;
`ifdef HC16_SCHED_CIN_EN
  logic [NUM_REQ-1:0]              req_cin;
`endif
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [ID_W-1:0]                 rsp_id;
  logic [MAX_WORDS*16-1:0]         rsp_sum;
  logic                            rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_nwords,
`ifdef HC16_SCHED_CIN_EN
    output req_cin,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_nwords,
`ifdef HC16_SCHED_CIN_EN
    input  req_cin,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/hc16_mw_add_sched_rr_arb.sv
// Round-robin requester pick with a registered pointer that moves past each grant.
module hc16_rr_arb
  import hc16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         valid,
  input  logic                       take,
  output logic [$clog2(NUM_REQ)-1:0] gnt,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  assign gnt = IDX_W'(rr_pick(8'(valid), 3'(ptr_q), 3'(NUM_REQ - 1)));
  assign any = |valid;

  // Pointer advances to one past the granted requester; power-of-2 width wraps it.
  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = gnt + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hc16_mw_add_sched.sv
// Time-shares one external 16-bit adder among requesters for multi-word additions,
// injecting inter-word carry with an extra +1 pass. HC16_SCHED_CIN_EN adds req_cin.
module hc16_mw_add_sched
  import hc16_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hc16_mw_add_sched_if.slave       bus,
  output word_t                    add_a,
  output word_t                    add_b,
  input  word_t                    add_sum,
  input  logic                     add_cout,
  output logic                     busy
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int LANE_W = MAX_WORDS * WORD_W;

  state_t           state_q, state_d;
  logic [1:0]       w_q, w_d;
  logic [1:0]       nwords_q, nwords_d;
  logic             carry_q, carry_d;
  logic             c1_q, c1_d;
  logic [ID_W-1:0]  id_q, id_d;
  word_t            a_q   [MAX_WORDS];
  word_t            a_d   [MAX_WORDS];
  word_t            b_q   [MAX_WORDS];
  word_t            b_d   [MAX_WORDS];
  word_t            sum_q [MAX_WORDS];
  word_t            sum_d [MAX_WORDS];

  logic [ID_W-1:0]    gnt_s;
  logic               any_s;
  logic               take_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [LANE_W-1:0]  lane_a_s;
  logic [LANE_W-1:0]  lane_b_s;
  logic [LANE_W-1:0]  rsp_sum_s;
  logic [1:0]         nw_raw_s;
  logic [1:0]         nw_s;
  word_t              add_a_s;
  word_t              add_b_s;

  hc16_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (bus.req_valid),
    .take  (take_s),
    .gnt   (gnt_s),
    .any   (any_s)
  );

  assign lane_a_s = bus.req_a[gnt_s*LANE_W +: LANE_W];
  assign lane_b_s = bus.req_b[gnt_s*LANE_W +: LANE_W];
  assign nw_raw_s = bus.req_nwords[gnt_s*2 +: 2];

  // Oversized word counts are clamped to the widest supported operand.
  always_comb begin
    nw_s = nw_raw_s;
    if (int'(nw_raw_s) > MAX_WORDS - 1) begin
      nw_s = 2'(MAX_WORDS - 1);
    end else begin
      nw_s = nw_raw_s;
    end
  end

  // FSM next state, datapath updates and adder operand muxing.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    nwords_d = nwords_q;
    carry_d  = carry_q;
    c1_d     = c1_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    ready_s  = '0;
    take_s   = 1'b0;
    add_a_s  = 16'h0000;
    add_b_s  = 16'h0000;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          ready_s[gnt_s] = 1'b1;
          take_s         = 1'b1;
          id_d           = gnt_s;
          nwords_d       = nw_s;
          w_d            = 2'd0;
`ifdef HC16_SCHED_CIN_EN
          carry_d        = bus.req_cin[gnt_s];
`else
          carry_d        = 1'b0;
`endif
          for (int k = 0; k < MAX_WORDS; k++) begin
            a_d[k]   = lane_a_s[k*WORD_W +: WORD_W];
            b_d[k]   = lane_b_s[k*WORD_W +: WORD_W];
            sum_d[k] = 16'h0000;
          end
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        add_a_s    = a_q[w_q];
        add_b_s    = b_q[w_q];
        sum_d[w_q] = add_sum;
        c1_d       = add_cout;
        if (carry_q) begin
          state_d = INC;
        end else begin
          carry_d = add_cout;
          if (w_q == nwords_q) begin
            state_d = RESP;
          end else begin
            w_d     = w_q + 2'd1;
            state_d = ADD;
          end
        end
      end
      INC: begin
        // Pending carry-in is applied as a +1 pass on the partial word.
        add_a_s    = sum_q[w_q];
        add_b_s    = 16'h0001;
        sum_d[w_q] = add_sum;
        carry_d    = c1_q | add_cout;
        if (w_q == nwords_q) begin
          state_d = RESP;
        end else begin
          w_d     = w_q + 2'd1;
          state_d = ADD;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pack result words onto the flat response bus.
  always_comb begin
    rsp_sum_s = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      rsp_sum_s[k*WORD_W +: WORD_W] = sum_q[k];
    end
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w_q      <= 2'd0;
      nwords_q <= 2'd0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      id_q     <= '0;
      a_q      <= '{default: 16'h0000};
      b_q      <= '{default: 16'h0000};
      sum_q    <= '{default: 16'h0000};
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      nwords_q <= nwords_d;
      carry_q  <= carry_d;
      c1_q     <= c1_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  assign bus.req_ready = ready_s & {NUM_REQ{rst_n}};
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = rsp_sum_s;
  assign bus.rsp_cout  = carry_q;
  assign add_a         = add_a_s;
  assign add_b         = add_b_s;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_hc16_mw_add_sched.sv
// Scoreboard bench for hc16_mw_add_sched: directed requests push expectations,
// a monitor checks each response against the queue head.
module tb_hc16_mw_add_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cout;
  logic        busy;

  always #5 clk = ~clk;

  hc16_mw_add_sched_if #(.NUM_REQ(4), .MAX_WORDS(4)) bus ();

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  hc16_mw_add_sched #(.NUM_REQ(4), .MAX_WORDS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy)
  );

  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        cout;
    int          lat;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int id, input logic [63:0] a, input logic [63:0] b, input logic [1:0] nw);
    bus.req_a[id*64 +: 64]    = a;
    bus.req_b[id*64 +: 64]    = b;
    bus.req_nwords[id*2 +: 2] = nw;
  endtask

  task automatic push_exp(input int id, input logic [63:0] s, input logic c, input int lat);
    exp_t e;
    e.id = id; e.sum = s; e.cout = c; e.lat = lat; e.gcyc = cyc;
    sb.push_back(e);
  endtask

  task automatic grant_one(input int id, output int got);
    got = -1;
    for (int i = 0; i < 100 && got < 0; i++) begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) if (bus.req_ready[r]) got = r;
    end
    if (got < 0) begin
      total++; bad++;
      $display("FAIL grant_timeout: got no req_ready, expected requester %0d", id);
    end else begin
      chk("grant_id", 64'(got), 64'(id));
    end
  endtask

  task automatic do_req(input int id, input logic [63:0] a, input logic [63:0] b, input logic [1:0] nw,
                        input logic [63:0] es, input logic ec, input int el);
    int got;
    @(posedge clk); #1;
    set_vec(id, a, b, nw);
    bus.req_valid[id] = 1'b1;
    grant_one(id, got);
    if (got >= 0) push_exp(id, es, ec, el);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle with 0 pending", busy, sb.size());
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},      64'(busy),          64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_add_a"},     64'(add_a),         64'd0);
    chk({tag, "_add_b"},     64'(add_b),         64'd0);
    chk({tag, "_rsp_sum"},   bus.rsp_sum,        64'd0);
    chk({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
    chk({tag, "_rsp_cout"},  64'(bus.rsp_cout),  64'd0);
  endtask

  // Response monitor: checks every valid cycle against the queue head, pops on handshake.
  initial begin
    bit seen = 1'b0;
    int rise_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got rsp_id=%0d sum=%h, expected no response", bus.rsp_id, bus.rsp_sum);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            rise_cyc = cyc;
          end
          chk("rsp_sum_held", bus.rsp_sum, sb[0].sum);
          if (bus.rsp_ready) begin
            e = sb.pop_front();
            chk("rsp_id",   64'(bus.rsp_id),   64'(e.id));
            chk("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
            chk("latency",  64'(rise_cyc - e.gcyc), 64'(e.lat));
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int got;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_nwords = '0;
`ifdef HC16_SCHED_CIN_EN
    bus.req_cin    = '0;
`endif
    bus.rsp_ready  = 1'b1;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word with carry out, then two-word carry propagation cases.
    do_req(0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 2'd0, 64'h0000_0000_0000_0000, 1'b1, 2);
    wait_idle();
    do_req(1, 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 2'd1, 64'h0000_0000_0002_0000, 1'b0, 4);
    wait_idle();
    do_req(2, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2'd1, 64'h0000_0000_0000_0000, 1'b1, 4);
    wait_idle();

    // Response back-pressure while another requester waits.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_req(3, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 2'd3, 64'h2345_6789_ABCD_F001, 1'b0, 5);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1;
    end
    chk("hold_rsp_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    set_vec(0, 64'hAAAA_AAAA_AAAA_8000, 64'h5555_0000_0000_8000, 2'd0);
    bus.req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready    = 1'b1;
    wait_idle();

    // All requesters held valid: pointer must rotate 0,1,2,3 and wrap to 0.
    @(posedge clk); #1;
    set_vec(1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2'd2);
    set_vec(2, 64'hFFFF_0000_0000_0001, 64'h0001_0000_0000_0002, 2'd3);
    set_vec(3, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 2'd3);
    bus.req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      case (g % 4)
        0: begin grant_one(0, got); push_exp(0, 64'h0000_0000_0000_0000, 1'b1, 2); end
        1: begin grant_one(1, got); push_exp(1, 64'h0000_0001_0000_0000, 1'b0, 6); end
        2: begin grant_one(2, got); push_exp(2, 64'h0000_0000_0000_0003, 1'b1, 5); end
        default: begin grant_one(3, got); push_exp(3, 64'h2345_6789_ABCD_F001, 1'b0, 5); end
      endcase
    end
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    wait_idle();

    // Reset landing in an INC pass discards the work and rewinds the pointer.
    @(posedge clk); #1;
    set_vec(1, 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 2'd1);
    bus.req_valid[1] = 1'b1;
    grant_one(1, got);
    push_exp(1, 64'h0000_0000_0002_0000, 1'b0, 4);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("inc_add_a", 64'(add_a), 64'h0001);
    chk("inc_add_b", 64'(add_b), 64'h0001);
    chk("inc_busy",  64'(busy),  64'd1);
    #1;
    rst_n = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(negedge clk);
    chk_zero_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_vec(0, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 2'd0);
    set_vec(2, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 2'd0);
    bus.req_valid = 4'b0101;
    grant_one(0, got);
    push_exp(0, 64'h0000_0000_0000_000C, 1'b0, 2);
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hc16_mw_add_sched.md
Name: hc16_mw_add_sched

Overview:
- Round-robin scheduler that time-shares one combinational 16-bit Han-Carlson adder among NUM_REQ requesters.
- Each request is a multi-word unsigned addition of 1..MAX_WORDS 16-bit words.
- The adder has no carry-in, so the block injects inter-word carry by a second "increment" pass through the same adder.
- Sits between requester clients and the shared adder instance; the adder's operand and result ports are driven and read by this block.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, 2..8)
- MAX_WORDS, 4, maximum operand length in 16-bit words (1..4)
- WORD_W, 16, word width; fixed to the adder width, not overridable

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot; high for one cycle in the grant cycle
- req_a  in  NUM_REQ*MAX_WORDS*16  operand A; requester r at slice r; word 0 = LSW
- req_b  in  NUM_REQ*MAX_WORDS*16  operand B, same layout
- req_nwords  in  NUM_REQ*2  word count minus 1 per requester
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_sum  out  MAX_WORDS*16  sum; words above nwords are zero
- rsp_cout  out  1  carry out of the top word
- add_a  out  16  shared-adder operand A
- add_b  out  16  shared-adder operand B
- add_sum  in  16  shared-adder sum (combinational from add_a/add_b)
- add_cout  in  1  shared-adder carry out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, rr pointer=0, all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, busy). In-flight work is discarded, with no response. Takes effect mid-operation on the same edge.
- FSM states and transitions:
  - IDLE: when any req_valid is set, grant the first valid requester at or after the rr pointer (wrap-around). Assert its req_ready this cycle and latch its A, B, nwords (and cin if enabled). Set carry=0, w=0, rr pointer=grant+1 mod NUM_REQ. Next state ADD.
  - ADD: add_a=A[w], add_b=B[w]; capture sum_w=add_sum, c1=add_cout. If carry=1, go to INC. Otherwise carry=c1 and advance.
  - INC: add_a=sum_w, add_b=16'h0001; sum_w=add_sum, carry=c1|add_cout; advance.
  - Advance: if w==nwords, go to RESP; else w++ and go to ADD.
  - RESP: rsp_valid=1. rsp_sum, rsp_id and rsp_cout=carry are stable until rsp_ready=1. On handshake, go to IDLE, rsp_valid=0 next cycle.
- Grants occur only in IDLE; no new grant while a response is pending.
- c1 and the increment carry are never both 1.
- add_a/add_b are registered-free muxes of FSM state; they are 0 in IDLE and RESP.
- Latency from grant edge to rsp_valid: 1 + sum over words of (1, or 2 if carry-in to that word). Example: a 1-word request asserts rsp_valid 2 cycles after the grant cycle.
- A requester dropping req_valid before grant is ignored; no commitment exists before req_ready.
- req_nwords greater than MAX_WORDS-1 is clamped to MAX_WORDS-1.

Optional Feature:
- Macro: HC16_SCHED_CIN_EN.
- Defined: adds port req_cin (in, NUM_REQ). The granted requester's cin is latched as the initial carry, so word 0 takes an INC pass when cin=1.
- Undefined: port absent; initial carry is fixed at 0.

Decomposition:
- Package hc16_sched_pkg holds:
  - typedef state_t (IDLE, ADD, INC, RESP)
  - WORD_W=16
  - typedef word_t
  - function rr_pick(valid, ptr) returning the granted index
- Sub-module hc16_rr_arb (combinational round-robin pick plus registered pointer) is the natural split.
- The adder stays external.

Test Plan:
- req0 1 word, A=0xFFFF, B=0x0001 -> rsp_id=0, rsp_sum[15:0]=0x0000, rsp_cout=1, rsp_valid 2 cycles after grant.
- req1 2 words, A=0x0001_FFFF, B=0x0000_0001 -> add cycles ADD, ADD, INC; sum=0x0002_0000, cout=0.
- req2 2 words, A=0xFFFF_FFFF, B=0x0000_0001 -> word1 INC carries; sum=0x0000_0000, cout=1.
- All 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0; rr pointer wraps.
- rsp_ready low 5 cycles, req3 valid -> rsp_valid and rsp_sum held stable, req_ready stays 0 until handshake.
- rst_n low during INC -> all outputs 0 next edge, no response emitted, next grant goes to req0.
